pong_game_ctrl: RTL and testbench
=================================

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 9: score at which a player wins; legal range 1..9.
REQ-002 Parameter DELAY_FRAMES, default 120: frames the ball is held after a miss; legal range 1..255.
REQ-003 clk  input  1  system clock; the only clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 frame_tick  input  1  one-cycle pulse per frame, issued when the video is off.
REQ-006 key  input  4  player buttons, active-low, asynchronous; key[1:0] player 1, key[3:2] player 2.
REQ-007 miss1  input  1  player 1 missed the ball; valid only on frame_tick cycles.
REQ-008 miss2  input  1  player 2 missed the ball; valid only on frame_tick cycles.
REQ-009 stop  output  1  registered; 1 holds the game graphics at the centred default.
REQ-010 score1, score2  output  4 each  registered BCD scores, range 0..WIN_SCORE.
REQ-011 game_over  output  1  registered; 1 in state OVER.
REQ-012 winner  output  1  registered; 0 = player 1 won, 1 = player 2 won; meaningful only when game_over=1.
REQ-013 state_o  output  2  current state encoding, used by the text overlay.

Function
REQ-014 The state machine SHALL have four states: NEWGAME=00, PLAY=01, NEWBALL=10, OVER=11.
REQ-015 key SHALL pass through a 2-flop synchroniser; key_press = any synchronised bit that is 1 in the previous cycle and 0 in the current cycle.
REQ-016 NEWGAME: stop=1, scores=0; on key_press, go to PLAY.
REQ-017 PLAY: stop=0; on frame_tick with miss1=1, increment score2; with miss2=1, increment score1.
REQ-018 When miss1 and miss2 are both 1 on the same frame_tick, only miss1 SHALL count (score2 increments).
REQ-019 After a counted miss, if the incremented score equals WIN_SCORE, go to OVER and set winner to the scorer; otherwise go to NEWBALL.
REQ-020 The new score, state and stop=1 SHALL be visible on the cycle after the frame_tick that carried the miss (latency 1).
REQ-021 miss1 and miss2 SHALL be ignored when frame_tick=0 and in every state other than PLAY.
REQ-022 NEWBALL: stop=1; an 8-bit timer loads DELAY_FRAMES on entry and decrements on each frame_tick.
REQ-023 NEWBALL SHALL go to PLAY on the frame_tick on which the timer equals 1, so the ball is held for exactly DELAY_FRAMES frame_ticks; key_press has no effect in NEWBALL.
REQ-024 OVER: stop=1, game_over=1, scores held; on key_press, clear both scores and winner and go to NEWGAME.
REQ-025 A key_press in PLAY SHALL be ignored, because the bar controls use the same keys.
REQ-026 The timer SHALL never wrap below 0; when frame_tick is 0 it holds its value.
REQ-027 Score increments SHALL be BCD; values never exceed WIN_SCORE, so no carry digit is needed.
REQ-028 state_o SHALL equal the registered state; stop and game_over SHALL be registered outputs with no combinational path from any input.

Reset
REQ-029 When rst=1 at a clock edge, on the next cycle: state=NEWGAME, stop=1, score1=score2=0, game_over=0, winner=0, timer=0, synchroniser and edge-detect flops all 1 (released).
REQ-030 rst asserted mid-game, in any state, SHALL abandon the game and apply REQ-029 with no partial scoring.
REQ-031 No key_press SHALL be detected on the first cycle after reset, even if a key is held low through reset.

Verification
REQ-032 Reset, then press key[0] (low for 4 cycles) -> state_o 00 to 01 three cycles after the press, stop=0.
REQ-033 In PLAY, frame_tick with miss2=1 -> next cycle score1=1, state_o=10, stop=1; after exactly 120 further frame_ticks, state_o=01 and stop=0.
REQ-034 In PLAY, frame_tick with miss1=miss2=1 -> score2 +1, score1 unchanged; miss1=1 without frame_tick -> no change.
REQ-035 score2=8 with WIN_SCORE=9, then frame_tick with miss1=1 -> state_o=11, game_over=1, winner=1; key_press -> state_o=00, scores=0, game_over=0.
REQ-036 rst=1 during NEWBALL with timer=50 and score1=3 -> next cycle state_o=00, score1=0, timer=0; a key held low through reset gives no start until released and pressed again.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: start/serve/score/game-over state machine with BCD scores,
// a key synchroniser with falling-edge detect, and the post-miss ball-hold timer.
module pong_game_ctrl #(
    parameter int unsigned WIN_SCORE    = 9,
    parameter int unsigned DELAY_FRAMES = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [3:0] key,
    input  logic       miss1,
    input  logic       miss2,
    output logic       stop,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       game_over,
    output logic       winner,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        NEWGAME = 2'b00,
        PLAY    = 2'b01,
        NEWBALL = 2'b10,
        OVER    = 2'b11
    } state_t;

    localparam logic [3:0] WinScore = 4'(WIN_SCORE);
    localparam logic [7:0] Delay    = 8'(DELAY_FRAMES);

    state_t     state;
    logic [7:0] timer;
    logic [3:0] key_s1;
    logic [3:0] key_s2;
    logic [3:0] key_prev;
    logic [1:0] sync_valid;
    logic [3:0] key_arm;
    logic       key_press;
    logic [3:0] score1_inc;
    logic [3:0] score2_inc;

    // A key only arms once it has been seen released after reset, so a key held
    // through reset cannot start a game until it is let go and pressed again.
    assign key_press  = |(key_arm & key_prev & ~key_s2);
    assign score1_inc = score1 + 4'd1;
    assign score2_inc = score2 + 4'd1;
    assign state_o    = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= NEWGAME;
            stop       <= 1'b1;
            score1     <= 4'd0;
            score2     <= 4'd0;
            game_over  <= 1'b0;
            winner     <= 1'b0;
            timer      <= 8'd0;
            key_s1     <= 4'hF;
            key_s2     <= 4'hF;
            key_prev   <= 4'hF;
            sync_valid <= 2'b00;
            key_arm    <= 4'h0;
        end else begin
            key_s1     <= key;
            key_s2     <= key_s1;
            key_prev   <= key_s2;
            sync_valid <= {sync_valid[0], 1'b1};
            // key_s2 carries a real sample only once sync_valid[1] is set.
            key_arm    <= key_arm | ({4{sync_valid[1]}} & key_s2);

            unique case (state)
                NEWGAME: begin
                    stop   <= 1'b1;
                    score1 <= 4'd0;
                    score2 <= 4'd0;
                    if (key_press) begin
                        state <= PLAY;
                        stop  <= 1'b0;
                    end
                end
                PLAY: begin
                    if (frame_tick && (miss1 || miss2)) begin
                        stop <= 1'b1;
                        // Simultaneous misses credit only player 2.
                        if (miss1) begin
                            score2 <= score2_inc;
                            if (score2_inc == WinScore) begin
                                state     <= OVER;
                                game_over <= 1'b1;
                                winner    <= 1'b1;
                            end else begin
                                state <= NEWBALL;
                                timer <= Delay;
                            end
                        end else begin
                            score1 <= score1_inc;
                            if (score1_inc == WinScore) begin
                                state     <= OVER;
                                game_over <= 1'b1;
                                winner    <= 1'b0;
                            end else begin
                                state <= NEWBALL;
                                timer <= Delay;
                            end
                        end
                    end
                end
                NEWBALL: begin
                    stop <= 1'b1;
                    if (frame_tick) begin
                        if (timer != 8'd0) begin
                            timer <= timer - 8'd1;
                        end
                        if (timer == 8'd1) begin
                            state <= PLAY;
                            stop  <= 1'b0;
                        end
                    end
                end
                OVER: begin
                    stop      <= 1'b1;
                    game_over <= 1'b1;
                    if (key_press) begin
                        state     <= NEWGAME;
                        score1    <= 4'd0;
                        score2    <= 4'd0;
                        winner    <= 1'b0;
                        game_over <= 1'b0;
                    end
                end
                default: state <= NEWGAME;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with default parameters (WIN_SCORE=9, DELAY_FRAMES=120).
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic [3:0] key = 4'hF;
    logic       miss1 = 1'b0;
    logic       miss2 = 1'b0;
    logic       stop;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       game_over;
    logic       winner;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;

    pong_game_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .frame_tick(frame_tick),
        .key       (key),
        .miss1     (miss1),
        .miss2     (miss2),
        .stop      (stop),
        .score1    (score1),
        .score2    (score2),
        .game_over (game_over),
        .winner    (winner),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    // Inputs change just after a falling edge; outputs are sampled there too.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic m1, input logic m2);
        frame_tick = 1'b1;
        miss1      = m1;
        miss2      = m2;
        step(1);
        frame_tick = 1'b0;
        miss1      = 1'b0;
        miss2      = 1'b0;
        step(1);
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    task automatic press(input int bit_idx);
        key          = 4'hF;
        key[bit_idx] = 1'b0;
        step(4);
        key = 4'hF;
        step(3);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        chk("rst_state", 8'(state_o), 8'h0);
        chk("rst_stop", 8'(stop), 8'h1);
        chk("rst_score1", 8'(score1), 8'h0);
        chk("rst_score2", 8'(score2), 8'h0);
        chk("rst_game_over", 8'(game_over), 8'h0);
        chk("rst_winner", 8'(winner), 8'h0);
        step(5);

        // Start: state changes on the third edge after key goes low
        key = 4'hE;
        step(2);
        chk("start_not_early", 8'(state_o), 8'h0);
        step(1);
        chk("start_state", 8'(state_o), 8'h1);
        chk("start_stop", 8'(stop), 8'h0);
        step(1);
        key = 4'hF;
        step(2);

        // Player 2 misses -> score1 and ball hold
        tick(1'b0, 1'b1);
        chk("miss2_score1", 8'(score1), 8'h1);
        chk("miss2_state", 8'(state_o), 8'h2);
        chk("miss2_stop", 8'(stop), 8'h1);
        // key press in NEWBALL has no effect
        press(1);
        idle_ticks(119);
        chk("hold_119", 8'(state_o), 8'h2);
        tick(1'b0, 1'b0);
        chk("hold_done_state", 8'(state_o), 8'h1);
        chk("hold_done_stop", 8'(stop), 8'h0);

        // miss without frame_tick ignored
        miss1 = 1'b1;
        step(1);
        miss1 = 1'b0;
        step(1);
        chk("nomiss_score2", 8'(score2), 8'h0);
        chk("nomiss_state", 8'(state_o), 8'h1);

        // Both misses: only player 1's miss counts
        tick(1'b1, 1'b1);
        chk("both_score2", 8'(score2), 8'h1);
        chk("both_score1", 8'(score1), 8'h1);
        chk("both_state", 8'(state_o), 8'h2);
        idle_ticks(120);
        chk("both_resume", 8'(state_o), 8'h1);

        // key press in PLAY ignored
        press(2);
        chk("play_key_ignored", 8'(state_o), 8'h1);

        // Drive score2 up to 8
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, 1'b0);
            idle_ticks(120);
        end
        chk("score2_eight", 8'(score2), 8'h8);
        chk("score2_eight_state", 8'(state_o), 8'h1);

        // Winning miss
        tick(1'b1, 1'b0);
        chk("win_state", 8'(state_o), 8'h3);
        chk("win_game_over", 8'(game_over), 8'h1);
        chk("win_winner", 8'(winner), 8'h1);
        chk("win_score2", 8'(score2), 8'h9);
        chk("win_stop", 8'(stop), 8'h1);
        tick(1'b0, 1'b1);
        chk("over_miss_ignored", 8'(score1), 8'h1);

        // Leave OVER
        press(3);
        chk("over_exit_state", 8'(state_o), 8'h0);
        chk("over_exit_score1", 8'(score1), 8'h0);
        chk("over_exit_score2", 8'(score2), 8'h0);
        chk("over_exit_game_over", 8'(game_over), 8'h0);
        chk("over_exit_winner", 8'(winner), 8'h0);

        // New game, score1 to 3, then reset mid-hold with timer at 50
        press(0);
        chk("game2_state", 8'(state_o), 8'h1);
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b1);
            idle_ticks(120);
        end
        tick(1'b0, 1'b1);
        idle_ticks(70);
        chk("midhold_state", 8'(state_o), 8'h2);
        chk("midhold_score1", 8'(score1), 8'h3);
        key = 4'hE;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_state", 8'(state_o), 8'h0);
        chk("midrst_score1", 8'(score1), 8'h0);
        chk("midrst_stop", 8'(stop), 8'h1);
        step(10);
        chk("held_key_no_start", 8'(state_o), 8'h0);
        key = 4'hF;
        step(5);
        chk("release_no_start", 8'(state_o), 8'h0);
        key = 4'hE;
        step(3);
        chk("repress_start", 8'(state_o), 8'h1);
        key = 4'hF;
        step(2);
        // Timer must restart from the full delay, not resume from 50
        tick(1'b0, 1'b1);
        idle_ticks(119);
        chk("timer_cleared_hold", 8'(state_o), 8'h2);
        tick(1'b0, 1'b0);
        chk("timer_cleared_resume", 8'(state_o), 8'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
